// File: rtl/counter_pkg.sv
// Shared types and helpers for the up/down modulo counter family.
package counter_pkg;

  typedef enum logic {
    DIR_DOWN = 1'b0,
    DIR_UP   = 1'b1
  } count_dir_e;

  typedef enum logic {
    MODE_WRAP = 1'b0,
    MODE_SAT  = 1'b1
  } count_mode_e;

  // A 1-cycle prescaler still needs a 1-bit register to stay well-formed.
  function automatic int presc_w(input int prescale);
    return (prescale <= 1) ? 1 : $clog2(prescale);
  endfunction

endpackage

// File: rtl/prescale_tick.sv
// Divides en-high cycles by PRESCALE and pulses tick on the last cycle of each period.
module prescale_tick
  import counter_pkg::*;
#(
  parameter int PRESCALE = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic sync_clr,
  output logic tick
);

  localparam int PW = presc_w(PRESCALE);
  localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);

  logic [PW-1:0] cnt;

  assign tick = en && (cnt == LAST);

  always_ff @(posedge clk) begin
    if (!rst_n || sync_clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= tick ? '0 : cnt + 1'b1;
    end
  end

endmodule

// File: rtl/updown_mod_counter.sv
// Parametrised up/down modulo counter with load, clear, wrap/saturate and terminal-count pulse.
// Optional prescaler is built when COUNTER_PRESCALE_EN is defined.
module updown_mod_counter
  import counter_pkg::*;
#(
  parameter int WIDTH    = 4,
  parameter int MAX_VAL  = 2**WIDTH - 1,
  parameter int PRESCALE = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             up,
  input  logic             sat,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] q,
  output logic             tc,
  output logic             at_max,
  output logic             at_min
);

  localparam logic [WIDTH-1:0] MAX_Q = WIDTH'(MAX_VAL);

  if (MAX_VAL < 1 || MAX_VAL > 2**WIDTH - 1) begin : g_bad_max
    $error("updown_mod_counter: MAX_VAL out of range");
  end
  if (PRESCALE < 1) begin : g_bad_presc
    $error("updown_mod_counter: PRESCALE must be >= 1");
  end

  logic step_ok;

`ifdef COUNTER_PRESCALE_EN
  prescale_tick #(
    .PRESCALE (PRESCALE)
  ) u_prescale (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (en),
    .sync_clr (clr | load),
    .tick     (step_ok)
  );
`else
  assign step_ok = en;
`endif

  function automatic logic at_bound(input logic [WIDTH-1:0] cur, input count_dir_e dir);
    return (dir == DIR_UP) ? (cur == MAX_Q) : (cur == '0);
  endfunction

  // Boundary compares come first so the arithmetic never leaves 0..MAX_VAL.
  function automatic logic [WIDTH-1:0] next_count(input logic [WIDTH-1:0] cur,
                                                  input count_dir_e dir,
                                                  input count_mode_e mode);
    if (at_bound(cur, dir)) begin
      if (mode == MODE_SAT) return cur;
      return (dir == DIR_UP) ? '0 : MAX_Q;
    end
    return (dir == DIR_UP) ? cur + 1'b1 : cur - 1'b1;
  endfunction

  function automatic logic [WIDTH-1:0] clamp_load(input logic [WIDTH-1:0] v);
    return (v > MAX_Q) ? MAX_Q : v;
  endfunction

  count_dir_e  dir;
  count_mode_e mode;

  assign dir  = count_dir_e'(up);
  assign mode = count_mode_e'(sat);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      q  <= '0;
      tc <= 1'b0;
    end else if (clr) begin
      q  <= '0;
      tc <= 1'b0;
    end else if (load) begin
      q  <= clamp_load(load_val);
      tc <= 1'b0;
    end else if (step_ok) begin
      q  <= next_count(q, dir, mode);
      tc <= at_bound(q, dir);
    end else begin
      tc <= 1'b0;
    end
  end

  assign at_max = (q == MAX_Q);
  assign at_min = (q == '0);

endmodule

// File: doc/updown_mod_counter.md
# updown_mod_counter

Parametrised synchronous up/down modulo counter, the generalised successor to the team's fixed 4-bit up counter. It adds programmable width and modulus, direction control, synchronous load and clear, wrap or saturate mode, and a registered terminal-count pulse. It sits in timer, event-count and sequencing paths, driven directly from the 100 MHz system clock domain.

## Interface
Parameters:
- WIDTH, 4, counter width in bits (≥1)
- MAX_VAL, 2**WIDTH-1, highest count value; the count range is 0..MAX_VAL (1 ≤ MAX_VAL ≤ 2**WIDTH-1)
- PRESCALE, 1, enabled cycles per count step; honoured only when COUNTER_PRESCALE_EN is defined (≥1)

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, synchronous, active-low
- en  in  1  count enable
- up  in  1  direction: 1 = increment, 0 = decrement
- sat  in  1  mode: 1 = saturate at bounds, 0 = wrap
- clr  in  1  synchronous clear to 0
- load  in  1  synchronous load of load_val
- load_val  in  WIDTH  load value
- q  out  WIDTH  current count
- tc  out  1  terminal-count pulse
- at_max  out  1  q == MAX_VAL (combinational from q)
- at_min  out  1  q == 0 (combinational from q)

## Operation
- All state updates occur on posedge clk. Priority order: rst_n low > clr > load > count step > hold.
- Reset (rst_n=0 at the edge): q=0, tc=0, prescaler state=0. After reset, at_min=1 and at_max=0 (at_max=1 only if MAX_VAL=0, which is illegal).
- clr: q←0, tc←0, prescaler←0. Ignores en, load and up.
- load: q←min(load_val, MAX_VAL), tc←0, prescaler←0. A load_val greater than MAX_VAL clamps to MAX_VAL.
- Step: occurs when en=1 and no clr/load is active (with the prescaler, only on the tick cycle).
  - up=1, q<MAX_VAL: q←q+1.
  - up=1, q==MAX_VAL: q←0 if sat=0; q holds if sat=1.
  - up=0, q>0: q←q-1.
  - up=0, q==0: q←MAX_VAL if sat=0; q holds if sat=1.
- tc←1 for any step taken at a boundary (up at MAX_VAL, or down at 0), in both wrap and saturate mode. Otherwise tc←0, so tc is never held longer than one cycle per boundary step. While the counter repeatedly steps at a saturated boundary, tc stays 1 on every such step.
- en=0 with no clr/load: q holds, tc←0.
- up and sat may change on any cycle. They are sampled only on the step cycle.

## Timing
- q and tc are registered, with 1-cycle latency from the sampled inputs. tc rises in the same cycle q shows the post-step value.
- at_max and at_min are pure decodes of q, with zero latency relative to q.
- No handshake. Every enabled cycle is one step (PRESCALE=1 or macro absent).
- Reset asserted mid-count overrides everything on that edge. Counting resumes on the first edge with rst_n=1 and en=1.
- Simultaneous clr and load: clr wins. Simultaneous load and en: load wins, and no step is taken that cycle.
- Arithmetic is performed at WIDTH bits, and the boundary compares make sure no intermediate value exceeds MAX_VAL.

## Configuration
- Macro: COUNTER_PRESCALE_EN.
- Defined: an internal prescaler counts en-high cycles 0..PRESCALE-1. A step occurs only on the en-high cycle at which the prescaler equals PRESCALE-1, and the prescaler then returns to 0. The prescaler freezes when en=0 and clears on reset, clr and load. With PRESCALE=1 the behaviour is identical to the macro-absent build.
- Absent: no prescaler logic is generated, the PRESCALE parameter is ignored, and a step occurs on every qualifying en-high cycle.

## Structure
- Shared package counter_pkg holds:
  - typedef count_dir_e (DIR_DOWN=0, DIR_UP=1)
  - typedef count_mode_e (MODE_WRAP=0, MODE_SAT=1)
  - localparam helper for the prescaler width, $clog2 of PRESCALE with a floor of 1
- Sub-module prescale_tick (parameter PRESCALE; ports clk, rst_n, en, sync_clr, tick) is instantiated only under COUNTER_PRESCALE_EN.
- Top-level parameter assertions (simulation only): MAX_VAL in range, PRESCALE≥1.

## Test plan
All scenarios use WIDTH=4, MAX_VAL=9.
- Reset then up-count: rst_n=0 for 2 cycles, then en=1, up=1, sat=0 for 12 cycles -> q 0,1,…,9,0,1,2; tc=1 only in the cycle q shows 0 after 9; at_max=1 when q=9.
- Down wrap: load load_val=1, then en=1, up=0, sat=0 -> q 1,0,9,8; tc=1 with q=9; at_min=1 with q=0.
- Saturate: load 8, en=1, up=1, sat=1 for 4 cycles -> q 8,9,9,9; tc=0,0,1,1. Then up=0 -> q 8, tc=0.
- Priority and clamp: load=1 with load_val=15 -> q=9. Next cycle clr=1, load=1, en=1 -> q=0, tc=0. Next, en=0 for 3 cycles -> q holds at 0.
- Reset mid-count: at q=5 with en=1, pulse rst_n=0 for 1 cycle -> q=0, tc=0 on that edge; the next enabled edge gives q=1.
- Prescaler (macro defined, PRESCALE=3): en=1, up=1 for 9 cycles -> q steps 0→1→2→3, once per 3 enabled cycles. Dropping en for 2 cycles mid-period delays the next step by 2 cycles. A load mid-period restarts the 3-cycle period.
